// File: rtl/stage_mem.sv
// stage_mem: pipeline MEM stage, one outstanding data-bus access with stall and load extension.
// Define RV_MEM_MISALIGN_EN to trap misaligned half/word accesses instead of issuing them.
module stage_mem #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 32
) (
    input  logic                  i_clock,
    input  logic                  i_reset,
    input  logic                  i_valid,
    input  logic [DATA_WIDTH-1:0] i_result,
    input  logic [DATA_WIDTH-1:0] i_dataB,
    input  logic                  i_memRead,
    input  logic                  i_memWrite,
    input  logic [1:0]            i_memAccess,
    input  logic                  i_memUnsigned,
    output logic                  o_hazard,
    output logic                  o_valid,
    output logic [DATA_WIDTH-1:0] o_result,
    output logic                  o_misaligned,
    output logic [ADDR_WIDTH-1:0] o_memAddr,
    output logic                  o_memRdEnable,
    output logic                  o_memWrEnable,
    output logic [31:0]           o_memWrData,
    output logic [3:0]            o_memWrMask,
    input  logic [31:0]           i_memRdData,
    input  logic                  i_memAck
);
    typedef enum logic {IDLE, ACCESS} state_t;
    state_t state, state_next;
    logic [ADDR_WIDTH-1:0] addr, addr_q;
    logic [1:0] size_q;
    logic uns_q, mem_req, misaligned, start;
    logic [3:0] wr_mask;
    logic [31:0] wr_data, load_data;
    logic [7:0] byte_lane;
    logic [15:0] half_lane;

    assign addr = ADDR_WIDTH'(i_result);
    assign mem_req = i_memRead | i_memWrite;
`ifdef RV_MEM_MISALIGN_EN
    assign misaligned = i_memAccess == 2'b01 ? addr[0] : i_memAccess[1] ? |addr[1:0] : 1'b0;
`else
    assign misaligned = 1'b0;
`endif
    assign start = state == IDLE && i_valid && mem_req && !misaligned;
    assign wr_mask = i_memAccess == 2'b00 ? 4'b0001 << addr[1:0] :
                     i_memAccess == 2'b01 ? 4'b0011 << {addr[1], 1'b0} : 4'b1111;
    assign wr_data = i_memAccess == 2'b00 ? {4{i_dataB[7:0]}} :
                     i_memAccess == 2'b01 ? {2{i_dataB[15:0]}} : i_dataB[31:0];
    assign byte_lane = 8'(i_memRdData >> {addr_q[1:0], 3'b000});
    assign half_lane = 16'(i_memRdData >> {addr_q[1], 4'b0000});
    assign load_data = size_q == 2'b00 ? {{24{~uns_q & byte_lane[7]}}, byte_lane} :
                       size_q == 2'b01 ? {{16{~uns_q & half_lane[15]}}, half_lane} : i_memRdData;

    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) state <= IDLE;
        else state <= state_next;
    end

    always_comb begin
        state_next = state == IDLE ? (start ? ACCESS : IDLE) : (i_memAck ? IDLE : ACCESS);
    end

    always_comb begin
        o_hazard = i_reset ? 1'b0 : state == IDLE ? start : !i_memAck;
    end

    // Operand capture in IDLE; completion (result, strobe release) on acknowledge in ACCESS.
    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) begin
            o_valid       <= 1'b0;
            o_result      <= '0;
            o_misaligned  <= 1'b0;
            o_memAddr     <= '0;
            o_memRdEnable <= 1'b0;
            o_memWrEnable <= 1'b0;
            o_memWrData   <= '0;
            o_memWrMask   <= '0;
            addr_q        <= '0;
            size_q        <= '0;
            uns_q         <= 1'b0;
        end else if (state == IDLE) begin
            o_valid      <= i_valid && !start;
            o_misaligned <= i_valid && mem_req && misaligned;
            if (i_valid) o_result <= mem_req ? DATA_WIDTH'(addr) : i_result;
            if (start) begin
                addr_q        <= addr;
                size_q        <= i_memAccess;
                uns_q         <= i_memUnsigned;
                o_memAddr     <= {addr[ADDR_WIDTH-1:2], 2'b00};
                o_memRdEnable <= i_memRead & ~i_memWrite;
                o_memWrEnable <= i_memWrite;
                o_memWrData   <= wr_data;
                o_memWrMask   <= wr_mask;
            end
        end else if (i_memAck) begin
            o_valid       <= 1'b1;
            o_misaligned  <= 1'b0;
            o_result      <= o_memWrEnable ? DATA_WIDTH'(addr_q) : DATA_WIDTH'(load_data);
            o_memRdEnable <= 1'b0;
            o_memWrEnable <= 1'b0;
        end
    end
endmodule

// File: tb/tb_stage_mem.sv
// tb_stage_mem: directed plus randomized checks of stage_mem against a byte-lane arithmetic model.
module tb_stage_mem;
    logic        i_clock = 1'b0;
    logic        i_reset, i_valid, i_memRead, i_memWrite, i_memUnsigned, i_memAck;
    logic [31:0] i_result, i_dataB, i_memRdData;
    logic [1:0]  i_memAccess;
    logic        o_hazard, o_valid, o_misaligned, o_memRdEnable, o_memWrEnable;
    logic [31:0] o_result, o_memAddr, o_memWrData;
    logic [3:0]  o_memWrMask;
    int checks = 0, errors = 0;
`ifdef RV_MEM_MISALIGN_EN
    localparam bit MIS_EN = 1'b1;
`else
    localparam bit MIS_EN = 1'b0;
`endif

    stage_mem #(.DATA_WIDTH(32), .ADDR_WIDTH(32)) dut (
        .i_clock(i_clock), .i_reset(i_reset), .i_valid(i_valid), .i_result(i_result),
        .i_dataB(i_dataB), .i_memRead(i_memRead), .i_memWrite(i_memWrite),
        .i_memAccess(i_memAccess), .i_memUnsigned(i_memUnsigned), .o_hazard(o_hazard),
        .o_valid(o_valid), .o_result(o_result), .o_misaligned(o_misaligned),
        .o_memAddr(o_memAddr), .o_memRdEnable(o_memRdEnable), .o_memWrEnable(o_memWrEnable),
        .o_memWrData(o_memWrData), .o_memWrMask(o_memWrMask), .i_memRdData(i_memRdData),
        .i_memAck(i_memAck)
    );

    always #5 i_clock = ~i_clock;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [3:0] exp_mask(input logic [1:0] sz, input logic [31:0] a);
        if (sz == 0) return 4'(1 << (a % 4));
        if (sz == 1) return 4'(3 << (2 * ((a / 2) % 2)));
        return 4'hF;
    endfunction

    function automatic logic [31:0] exp_wdata(input logic [1:0] sz, input logic [31:0] d);
        if (sz == 0) return (d & 32'hFF) * 32'h01010101;
        if (sz == 1) return (d & 32'hFFFF) * 32'h00010001;
        return d;
    endfunction

    function automatic logic [31:0] exp_load(input logic [1:0] sz, input bit uns, input logic [31:0] a, input logic [31:0] rd);
        logic [31:0] v;
        if (sz == 0) begin
            v = (rd >> (8 * (a % 4))) & 32'hFF;
            if (!uns && v >= 128) v = v + 32'hFFFFFF00;
        end else if (sz == 1) begin
            v = (rd >> (16 * ((a / 2) % 2))) & 32'hFFFF;
            if (!uns && v >= 32768) v = v + 32'hFFFF0000;
        end else v = rd;
        return v;
    endfunction

    task automatic alu_op(input logic [31:0] d);
        i_valid = 1; i_memRead = 0; i_memWrite = 0; i_result = d;
        i_memAck = 1'($urandom_range(0, 1));
        #1 check("alu_hazard", 32'(o_hazard), 0);
        @(posedge i_clock); #1;
        check("alu_valid", 32'(o_valid), 1);
        check("alu_result", o_result, d);
        check("alu_strobes", {30'd0, o_memRdEnable, o_memWrEnable}, 0);
        i_memAck = 0;
    endtask

    task automatic mem_op(input bit rd, input bit wr, input logic [1:0] sz, input bit uns,
                          input logic [31:0] a, input logic [31:0] d, input logic [31:0] rdata, input int delay);
        bit mis = MIS_EN && (sz == 1 ? (a % 2) != 0 : sz >= 2 ? (a % 4) != 0 : 1'b0);
        int hz = 0;
        i_valid = 1; i_memRead = rd; i_memWrite = wr; i_memAccess = sz; i_memUnsigned = uns;
        i_result = a; i_dataB = d; i_memAck = 0; i_memRdData = rdata;
        #1 check("req_hazard", 32'(o_hazard), 32'(!mis));
        hz += int'(o_hazard);
        @(posedge i_clock); #1;
        if (mis) begin
            check("mis_valid", 32'(o_valid), 1);
            check("mis_flag", 32'(o_misaligned), 1);
            check("mis_result", o_result, a);
            check("mis_strobes", {30'd0, o_memRdEnable, o_memWrEnable}, 0);
            i_valid = 0; i_memRead = 0; i_memWrite = 0;
            return;
        end
        check("acc_valid", 32'(o_valid), 0);
        for (int c = 0; c <= delay; c++) begin
            check("acc_addr", o_memAddr, a & 32'hFFFFFFFC);
            check("acc_rd", 32'(o_memRdEnable), 32'(rd && !wr));
            check("acc_wr", 32'(o_memWrEnable), 32'(wr));
            if (wr) begin
                check("acc_mask", 32'(o_memWrMask), 32'(exp_mask(sz, a)));
                check("acc_wdata", o_memWrData, exp_wdata(sz, d));
            end
            i_memAck = (c == delay);
            #1 check("acc_hazard", 32'(o_hazard), 32'(c != delay));
            hz += int'(o_hazard);
            @(posedge i_clock); #1;
        end
        i_memAck = 0; i_valid = 0; i_memRead = 0; i_memWrite = 0;
        check("done_valid", 32'(o_valid), 1);
        check("done_mis", 32'(o_misaligned), 0);
        check("done_result", o_result, wr ? a : exp_load(sz, uns, a, rdata));
        check("done_strobes", {30'd0, o_memRdEnable, o_memWrEnable}, 0);
        check("hazard_cycles", 32'(hz), 32'(delay + 1));
    endtask

    initial begin
        i_reset = 1; i_valid = 1; i_memRead = 1; i_memWrite = 0; i_memAccess = 2;
        i_memUnsigned = 0; i_result = 32'h40; i_dataB = 0; i_memRdData = 0; i_memAck = 0;
        #1;
        check("rst_valid", 32'(o_valid), 0);
        check("rst_result", o_result, 0);
        check("rst_hazard", 32'(o_hazard), 0);
        check("rst_strobes", {30'd0, o_memRdEnable, o_memWrEnable}, 0);
        check("rst_addr", o_memAddr, 0);
        check("rst_wdata_mask", o_memWrData | 32'(o_memWrMask), 0);
        repeat (2) @(posedge i_clock);
        #1 i_reset = 0; i_valid = 0; i_memRead = 0;
        @(posedge i_clock); #1;
        check("idle_valid", 32'(o_valid), 0);

        alu_op(32'h1234);
        mem_op(0, 1, 2'b00, 0, 32'h103, 32'hAB, 32'h0, 3);
        mem_op(1, 0, 2'b01, 0, 32'h202, 32'h0, 32'h8001FFFF, 0);
        mem_op(1, 0, 2'b01, 1, 32'h202, 32'h0, 32'h8001FFFF, 0);
        mem_op(1, 0, 2'b10, 0, 32'h06, 32'h0, 32'hCAFEF00D, 1);
        mem_op(1, 0, 2'b00, 0, 32'h01, 32'h0, 32'h00008000, 0);
        mem_op(1, 1, 2'b11, 0, 32'h10, 32'h55AA33CC, 32'h0, 0);

        i_valid = 0; i_memAck = 1;
        @(posedge i_clock); #1;
        check("idle_ack_valid", 32'(o_valid), 0);
        check("idle_ack_strobes", {30'd0, o_memRdEnable, o_memWrEnable}, 0);
        i_memAck = 0;

        for (int n = 0; n < 60; n++) begin
            if ($urandom_range(0, 2) == 0) alu_op($urandom);
            else begin
                int kind = $urandom_range(0, 2);
                mem_op(kind != 1, kind != 0, 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
                       $urandom, $urandom, $urandom, $urandom_range(0, 3));
            end
        end

        i_valid = 1; i_memRead = 1; i_memWrite = 0; i_memAccess = 2; i_result = 32'h40; i_memAck = 0;
        @(posedge i_clock); #1;
        check("pre_rst_rd", 32'(o_memRdEnable), 1);
        #2 i_reset = 1;
        #1;
        check("async_rst_rd", 32'(o_memRdEnable), 0);
        check("async_rst_valid", 32'(o_valid), 0);
        check("async_rst_hazard", 32'(o_hazard), 0);
        @(posedge i_clock); #1;
        i_reset = 0; i_valid = 0; i_memRead = 0; i_memAck = 1; i_memRdData = $urandom;
        @(posedge i_clock); #1;
        check("late_ack_valid", 32'(o_valid), 0);
        check("late_ack_result", o_result, 0);
        check("late_ack_rd", 32'(o_memRdEnable), 0);
        i_memAck = 0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/stage_mem.md
STAGE_MEM -- requirements
Module: stage_mem

Interface
REQ-001 Parameter DATA_WIDTH, default 32, data path width; only 32 is supported.
REQ-002 Parameter ADDR_WIDTH, default 32, width of the data-bus address.
REQ-003 i_clock  in  1  sole clock; all state updates on rising edge.
REQ-004 i_reset  in  1  reset; asynchronous, active-high.
REQ-005 i_valid  in  1  instruction from EX stage present.
REQ-006 i_result  in  DATA_WIDTH  EX ALU result; effective address for loads and stores.
REQ-007 i_dataB  in  DATA_WIDTH  store data (EX dataB passthrough).
REQ-008 i_memRead / i_memWrite  in  1 each  load / store request; both high counts as store.
REQ-009 i_memAccess  in  2  00 byte, 01 half, 10 word, 11 treated as word.
REQ-010 i_memUnsigned  in  1  load zero-extends when high, sign-extends when low.
REQ-011 o_hazard  out  1  combinational stall to upstream stages; EX/MEM operands held while high.
REQ-012 o_valid / o_result  out  1 / DATA_WIDTH  registered MEM/WB result and its qualifier.
REQ-013 o_misaligned  out  1  registered misalignment flag, qualified by o_valid.
REQ-014 o_memAddr  out  ADDR_WIDTH  registered word address, bits [1:0] always 0.
REQ-015 o_memRdEnable / o_memWrEnable  out  1 each  registered bus read / write strobes.
REQ-016 o_memWrData / o_memWrMask  out  32 / 4  registered lane-replicated store data and byte mask.
REQ-017 i_memRdData / i_memAck  in  32 / 1  bus read data; access-complete acknowledge.

Function
REQ-018 FSM states IDLE and ACCESS; one outstanding bus access maximum.
REQ-019 IDLE, i_valid with neither memory request: o_result<=i_result, o_valid<=1 next edge, o_hazard=0 (latency 1).
REQ-020 IDLE, i_valid with a memory request: o_hazard=1 that cycle; address, size, sign mode, store data, mask registered; strobes asserted; go ACCESS; o_valid<=0.
REQ-021 ACCESS: strobes, address, data and mask held stable; o_hazard=!i_memAck.
REQ-022 ACCESS with i_memAck: load gives o_result<=extended lane data, store gives o_result<=address; o_valid<=1; strobes deasserted; go IDLE (minimum memory latency 2).
REQ-023 i_valid low in IDLE: o_valid<=0; i_memAck in IDLE ignored.
REQ-024 Store mask: byte 0001<<a[1:0]; half 0011<<{a[1],0}; word 1111; data byte {4{d[7:0]}}, half {2{d[15:0]}}, word d.
REQ-025 Load extraction: byte lane a[1:0], half lane a[1], word whole; extended to 32 bits per i_memUnsigned.

Reset
REQ-026 i_reset high forces immediately IDLE, o_valid=0, o_result=0, o_misaligned=0, strobes=0, o_memAddr=0, o_memWrData=0, o_memWrMask=0.
REQ-027 Reset during ACCESS abandons the access without waiting for i_memAck; o_hazard is 0 while in reset.

Configuration
REQ-028 Macro RV_MEM_MISALIGN_EN defined: half with a[0]=1 or word with a[1:0]!=0 starts no bus access; next edge o_valid=1, o_misaligned=1, o_result=address, o_hazard=0.
REQ-029 Macro undefined: o_misaligned tied 0; misaligned low bits are ignored per REQ-024/025 and the access proceeds.

Verification
REQ-030 ALU op: i_valid=1, i_result=0x1234, no memory request -> next cycle o_valid=1, o_result=0x1234, strobes 0.
REQ-031 Store byte: addr 0x103, dataB 0xAB, ack after 3 ACCESS cycles -> o_memAddr=0x100, mask 1000, data 0xABABABAB, o_hazard high 4 cycles, o_result=0x103.
REQ-032 Load signed half: addr 0x202, bus data 0x8001FFFF, ack at once -> o_result=0xFFFF8001; unsigned -> 0x00008001.
REQ-033 Reset asserted in ACCESS before ack -> strobes and o_valid 0 without a clock edge; a later ack is ignored.
REQ-034 RV_MEM_MISALIGN_EN defined, word load addr 0x06 -> no strobe, o_misaligned=1, o_result=0x06; undefined -> read at 0x04.
